// File: rtl/audio_delay_fx_pkg.sv
// rtl/audio_delay_fx_pkg.sv - shared encodings and defaults for the audio delay effect
package audio_delay_fx_pkg;

    localparam int DEF_DW     = 10;
    localparam int DEF_AW     = 13;
    localparam int DEF_OFFSET = 512;

    typedef enum logic [1:0] {
        MODE_PASS   = 2'b00,
        MODE_ECHO   = 2'b01,
        MODE_FBECHO = 2'b10,
        MODE_MUTE   = 2'b11
    } mode_e;

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_IDLE  = 3'd1,
        ST_READ  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_CALC  = 3'd4
    } state_e;

endpackage

// File: rtl/audio_delay_fx_delay_ram.sv
// rtl/audio_delay_fx_delay_ram.sv - single-port delay-line RAM with registered read
//
// Ports:
//   clk    in   system clock
//   we     in   write enable
//   addr   in   AW-bit address, shared by read and write
//   wdata  in   DW-bit write word
//   rdata  out  DW-bit read word, one cycle after addr (old data on write)
//
// Kept free of reset and of any output logic so it maps onto block RAM.
module delay_ram #(
    parameter int DW = 10,
    parameter int AW = 13
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/audio_delay_fx.sv
// rtl/audio_delay_fx.sv - per-sample pass/echo/feedback-echo/mute processor with RAM delay line
//
// Ports:
//   sysclk      in   system clock
//   rst_n       in   synchronous active-low reset; restarts the RAM clear
//   mode        in   00 pass, 01 echo, 10 feedback echo, 11 mute
//   delay       in   echo delay in samples, 0 selects the full depth
//   gain_sh     in   arithmetic right shift applied to the delayed term
//   data_in     in   offset-binary ADC sample
//   data_valid  in   one-cycle strobe qualifying data_in
//   data_out    out  offset-binary processed sample, held between updates
//   out_valid   out  one-cycle strobe when data_out updates
//   clip        out  one-cycle strobe with out_valid when the sum saturated
//   overrun     out  sticky flag: a strobe arrived while a sample was in flight
//   busy        out  high whenever the FSM is not in IDLE
module audio_delay_fx
    import audio_delay_fx_pkg::*;
#(
    parameter int DW     = DEF_DW,
    parameter int AW     = DEF_AW,
    parameter int OFFSET = DEF_OFFSET
) (
    input  logic          sysclk,
    input  logic          rst_n,
    input  logic [1:0]    mode,
    input  logic [AW-1:0] delay,
    input  logic [1:0]    gain_sh,
    input  logic [DW-1:0] data_in,
    input  logic          data_valid,
    output logic [DW-1:0] data_out,
    output logic          out_valid,
    output logic          clip,
    output logic          overrun,
    output logic          busy
);

    localparam logic signed [DW-1:0] S_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] S_MIN = {1'b1, {(DW-1){1'b0}}};

    state_e               state_q,     state_d;
    logic [AW-1:0]        clr_addr_q,  clr_addr_d;
    logic [AW-1:0]        wr_ptr_q,    wr_ptr_d;
    logic signed [DW-1:0] x_q,         x_d;
    mode_e                mode_q,      mode_d;
    logic [AW-1:0]        delay_q,     delay_d;
    logic [1:0]           gain_q,      gain_d;
    logic [DW-1:0]        data_out_q,  data_out_d;
    logic                 out_valid_q, out_valid_d;
    logic                 clip_q,      clip_d;
    logic                 overrun_q,   overrun_d;

    logic                 ram_we;
    logic [AW-1:0]        ram_addr;
    logic [DW-1:0]        ram_wdata;
    logic [DW-1:0]        ram_rdata;

    logic [AW-1:0]        rd_addr;
    logic signed [DW-1:0] d_s;
    logic signed [DW-1:0] e_s;
    logic signed [DW:0]   sum_s;
    logic signed [DW-1:0] sat_s;
    logic                 sat_hit;
    logic signed [DW-1:0] y_s;
    logic signed [DW-1:0] store_s;
    logic                 y_clip;

    delay_ram #(
        .DW (DW),
        .AW (AW)
    ) u_delay_ram (
        .clk   (sysclk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // delay=0 wraps to wr_ptr itself, which still holds the sample from a full lap ago.
    assign rd_addr = wr_ptr_q - delay_q;

    always_comb begin
        d_s   = $signed(ram_rdata);
        e_s   = d_s >>> gain_q;
        sum_s = {x_q[DW-1], x_q} + {e_s[DW-1], e_s};
        sat_s   = sum_s[DW-1:0];
        sat_hit = 1'b0;
        // Overflow when the extra sign bit disagrees with the DW-bit result sign.
        if (sum_s[DW] != sum_s[DW-1]) begin
            sat_hit = 1'b1;
            sat_s   = sum_s[DW] ? S_MIN : S_MAX;
        end

        y_s     = x_q;
        store_s = x_q;
        y_clip  = 1'b0;
        case (mode_q)
            MODE_PASS: begin
                y_s = x_q;
            end
            MODE_ECHO: begin
                y_s    = sat_s;
                y_clip = sat_hit;
            end
            MODE_FBECHO: begin
                y_s     = sat_s;
                store_s = sat_s;
                y_clip  = sat_hit;
            end
            MODE_MUTE: begin
                y_s = '0;
            end
            default: begin
                y_s = x_q;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        wr_ptr_d    = wr_ptr_q;
        x_d         = x_q;
        mode_d      = mode_q;
        delay_d     = delay_q;
        gain_d      = gain_q;
        data_out_d  = data_out_q;
        out_valid_d = 1'b0;
        clip_d      = 1'b0;
        overrun_d   = overrun_q;
        ram_we      = 1'b0;
        ram_addr    = rd_addr;
        ram_wdata   = store_s;

        case (state_q)
            ST_CLEAR: begin
                ram_we     = 1'b1;
                ram_addr   = clr_addr_q;
                ram_wdata  = '0;
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == {AW{1'b1}}) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (data_valid) begin
                    x_d     = $signed({~data_in[DW-1], data_in[DW-2:0]});
                    mode_d  = mode_e'(mode);
                    delay_d = delay;
                    gain_d  = gain_sh;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (data_valid) overrun_d = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Address stays on rd_addr so the RAM output is still valid in CALC.
                if (data_valid) overrun_d = 1'b1;
                state_d = ST_CALC;
            end
            ST_CALC: begin
                if (data_valid) overrun_d = 1'b1;
                ram_we      = 1'b1;
                ram_addr    = wr_ptr_q;
                ram_wdata   = store_s;
                wr_ptr_d    = wr_ptr_q + 1'b1;
                data_out_d  = {~y_s[DW-1], y_s[DW-2:0]};
                out_valid_d = 1'b1;
                clip_d      = y_clip;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase

        // Keep an aborted CALC or CLEAR from writing on the reset edge.
        if (!rst_n) begin
            ram_we = 1'b0;
        end
    end

    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            state_q     <= ST_CLEAR;
            clr_addr_q  <= '0;
            wr_ptr_q    <= '0;
            x_q         <= '0;
            mode_q      <= MODE_PASS;
            delay_q     <= '0;
            gain_q      <= '0;
            data_out_q  <= DW'(OFFSET);
            out_valid_q <= 1'b0;
            clip_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            wr_ptr_q    <= wr_ptr_d;
            x_q         <= x_d;
            mode_q      <= mode_d;
            delay_q     <= delay_d;
            gain_q      <= gain_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            clip_q      <= clip_d;
            overrun_q   <= overrun_d;
        end
    end

    assign data_out  = data_out_q;
    assign out_valid = out_valid_q;
    assign clip      = clip_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_audio_delay_fx.sv
// tb/tb_audio_delay_fx.sv - directed table-driven bench for audio_delay_fx
module tb_audio_delay_fx;

    logic       sysclk;
    logic       rst_n;
    logic [1:0] mode;
    logic [3:0] delay;
    logic [1:0] gain_sh;
    logic [9:0] data_in;
    logic       data_valid;
    logic [9:0] data_out;
    logic       out_valid;
    logic       clip;
    logic       overrun;
    logic       busy;

    int n_vec;
    int n_err;

    audio_delay_fx #(
        .DW     (10),
        .AW     (4),
        .OFFSET (512)
    ) dut (
        .sysclk     (sysclk),
        .rst_n      (rst_n),
        .mode       (mode),
        .delay      (delay),
        .gain_sh    (gain_sh),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .clip       (clip),
        .overrun    (overrun),
        .busy       (busy)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    typedef struct {
        bit         rst;
        logic [1:0] mode;
        logic [3:0] dly;
        logic [1:0] gsh;
        logic [9:0] din;
        logic [9:0] exp_out;
        bit         exp_clip;
    } vec_t;

    vec_t vt [12];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Counts cycles from reset release until busy drops; optionally pokes data_valid mid-clear.
    task automatic wait_clear(input bit poke, output int cnt, output int ov_seen);
        cnt = 0;
        ov_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge sysclk);
            data_valid = (poke && k == 3);
            if (out_valid) ov_seen++;
            cnt++;
            if (!busy) break;
        end
        data_valid = 1'b0;
    endtask

    task automatic do_reset(input bit poke, input string tag);
        int cnt;
        int ovs;
        @(negedge sysclk);
        rst_n = 1'b0;
        data_valid = 1'b0;
        repeat (2) @(negedge sysclk);
        check({tag, "_rst_data_out"}, data_out, 512);
        check({tag, "_rst_out_valid"}, out_valid, 0);
        check({tag, "_rst_busy"}, busy, 1);
        rst_n = 1'b1;
        wait_clear(poke, cnt, ovs);
        check({tag, "_clear_cycles"}, cnt, 16);
        check({tag, "_clear_no_out"}, ovs, 0);
        check({tag, "_clear_overrun"}, overrun, 0);
    endtask

    task automatic send(input logic [1:0] m, input logic [3:0] d, input logic [1:0] g,
                        input logic [9:0] din, output logic [9:0] got, output bit gclip,
                        output int lat);
        mode = m;
        delay = d;
        gain_sh = g;
        data_in = din;
        data_valid = 1'b1;
        @(negedge sysclk);
        data_valid = 1'b0;
        mode = ~m;
        data_in = ~din;
        lat = -1;
        got = '0;
        gclip = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge sysclk);
            if (out_valid) begin
                lat = k;
                got = data_out;
                gclip = clip;
                break;
            end
        end
    endtask

    initial begin
        logic [9:0] got;
        bit         gc;
        int         lat;
        int         cnt;
        int         ovs;
        int         exp_v;

        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        mode = 2'b00;
        delay = 4'd0;
        gain_sh = 2'd0;
        data_in = 10'd0;
        data_valid = 1'b0;

        vt[0]  = '{1'b1, 2'b01, 4'd2, 2'd1, 10'd612,  10'd612,  1'b0};
        vt[1]  = '{1'b0, 2'b01, 4'd2, 2'd1, 10'd512,  10'd512,  1'b0};
        vt[2]  = '{1'b0, 2'b01, 4'd2, 2'd1, 10'd512,  10'd562,  1'b0};
        vt[3]  = '{1'b0, 2'b01, 4'd2, 2'd1, 10'd512,  10'd512,  1'b0};
        vt[4]  = '{1'b1, 2'b01, 4'd1, 2'd0, 10'd1000, 10'd1000, 1'b0};
        vt[5]  = '{1'b0, 2'b01, 4'd1, 2'd0, 10'd1000, 10'd1023, 1'b1};
        vt[6]  = '{1'b1, 2'b01, 4'd1, 2'd0, 10'd20,   10'd20,   1'b0};
        vt[7]  = '{1'b0, 2'b01, 4'd1, 2'd0, 10'd20,   10'd0,    1'b1};
        vt[8]  = '{1'b1, 2'b10, 4'd1, 2'd1, 10'd712,  10'd712,  1'b0};
        vt[9]  = '{1'b0, 2'b10, 4'd1, 2'd1, 10'd512,  10'd612,  1'b0};
        vt[10] = '{1'b0, 2'b10, 4'd1, 2'd1, 10'd512,  10'd562,  1'b0};
        vt[11] = '{1'b0, 2'b11, 4'd1, 2'd0, 10'd800,  10'd512,  1'b0};

        // Reset with a strobe during CLEAR, then a pass-through sample.
        do_reset(1'b1, "init");
        send(2'b00, 4'd3, 2'd2, 10'd700, got, gc, lat);
        check("pass_latency", lat, 3);
        check("pass_out", got, 700);
        check("pass_clip", gc, 0);
        @(negedge sysclk);
        check("pass_pulse_width", out_valid, 0);
        check("pass_hold", data_out, 700);

        for (int i = 0; i < 12; i++) begin
            if (vt[i].rst) do_reset(1'b0, $sformatf("v%0d", i));
            send(vt[i].mode, vt[i].dly, vt[i].gsh, vt[i].din, got, gc, lat);
            check($sformatf("v%0d_latency", i), lat, 3);
            check($sformatf("v%0d_out", i), got, vt[i].exp_out);
            check($sformatf("v%0d_clip", i), gc, vt[i].exp_clip);
        end

        // Strobe while in WAIT is dropped and latches overrun.
        do_reset(1'b0, "ovr");
        mode = 2'b01; delay = 4'd1; gain_sh = 2'd0; data_in = 10'd600;
        data_valid = 1'b1;
        @(negedge sysclk);
        data_valid = 1'b0;
        @(negedge sysclk);
        data_in = 10'd900;
        data_valid = 1'b1;
        @(negedge sysclk);
        data_valid = 1'b0;
        @(negedge sysclk);
        check("ovr_first_valid", out_valid, 1);
        check("ovr_first_out", data_out, 600);
        ovs = 0;
        repeat (6) begin
            @(negedge sysclk);
            if (out_valid) ovs++;
        end
        check("ovr_dropped", ovs, 0);
        check("ovr_flag", overrun, 1);
        send(2'b01, 4'd1, 2'd0, 10'd512, got, gc, lat);
        check("ovr_next_out", got, 600);
        check("ovr_sticky", overrun, 1);

        // Twenty samples with delay=0: the echo term comes from sixteen samples back.
        do_reset(1'b0, "wrap");
        for (int i = 0; i < 20; i++) begin
            send(2'b01, 4'd0, 2'd0, 10'(512 + 5 * i), got, gc, lat);
            exp_v = (i < 16) ? (512 + 5 * i) : (512 + 5 * i + 5 * (i - 16));
            check($sformatf("wrap%0d_out", i), got, exp_v);
        end

        // Reset during WAIT aborts the sample and reclears the delay line.
        do_reset(1'b0, "mid");
        send(2'b01, 4'd0, 2'd0, 10'd900, got, gc, lat);
        check("mid_pre_out", got, 900);
        mode = 2'b01; delay = 4'd0; gain_sh = 2'd0; data_in = 10'd700;
        data_valid = 1'b1;
        @(negedge sysclk);
        data_valid = 1'b0;
        @(negedge sysclk);
        rst_n = 1'b0;
        @(negedge sysclk);
        check("mid_rst_no_valid", out_valid, 0);
        rst_n = 1'b1;
        wait_clear(1'b0, cnt, ovs);
        check("mid_clear_cycles", cnt, 16);
        check("mid_no_out", ovs, 0);
        check("mid_data_out", data_out, 512);
        send(2'b01, 4'd0, 2'd0, 10'd512, got, gc, lat);
        check("mid_post_out", got, 512);
        check("mid_post_latency", lat, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
